// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer_pkg
// Purpose  : Shared ALU opcode and sequencer command encodings.
// Revision : 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_NOT = 3'b101,
    ALU_NOP = 3'b111
  } e_alu_op;

  typedef enum logic [2:0] {
    CMD_ADD = 3'b000,
    CMD_SUB = 3'b001,
    CMD_AND = 3'b010,
    CMD_OR  = 3'b011,
    CMD_EQ  = 3'b100,
    CMD_NEG = 3'b101,
    CMD_XOR = 3'b110,
    CMD_MUL = 3'b111
  } e_seq_cmd;

endpackage
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_sequencer
// Purpose  : Multi-pass command sequencer driving an external combinational ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WORD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  e_seq_cmd        req_cmd,
  input  logic [WORD-1:0] req_a,
  input  logic [WORD-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_data,
  output logic            rsp_zero,
  output e_alu_op         alu_op,
  output logic [WORD-1:0] alu_a,
  output logic [WORD-1:0] alu_b,
  input  logic [WORD-1:0] alu_result,
  input  logic            alu_zero
);

  localparam int STEP_W = ($clog2(WORD) < 2) ? 2 : $clog2(WORD);
  localparam logic [STEP_W-1:0] c_mul_last = STEP_W'(WORD - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state, w_state_next;
  e_seq_cmd            r_cmd;
  logic [WORD-1:0]     r_a, r_b, r_acc, r_aux;
  logic [STEP_W-1:0]   r_step;
  logic [WORD-1:0]     r_rsp_data;
  logic                r_rsp_zero;
  logic                w_last, w_to_aux;
  logic [WORD-1:0]     w_rsp_next;
  logic                w_unused_zero;

  assign w_unused_zero = alu_zero;
  assign rsp_data      = r_rsp_data;
  assign rsp_zero      = r_rsp_zero;
  assign w_rsp_next    = (r_cmd == CMD_EQ) ? {{(WORD-1){1'b0}}, (alu_result == '0)} : alu_result;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    alu_op       = ALU_NOP;
    alu_a        = '0;
    alu_b        = '0;
    w_last       = 1'b0;
    w_to_aux     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = S_EXEC;
      end
      S_EXEC: begin
        // One ALU pass per cycle, selected by (cmd, step).
        case (r_cmd)
          CMD_ADD: begin alu_op = ALU_ADD; alu_a = r_a; alu_b = r_b; w_last = 1'b1; end
          CMD_SUB: begin alu_op = ALU_SUB; alu_a = r_a; alu_b = r_b; w_last = 1'b1; end
          CMD_AND: begin alu_op = ALU_AND; alu_a = r_a; alu_b = r_b; w_last = 1'b1; end
          CMD_OR:  begin alu_op = ALU_OR;  alu_a = r_a; alu_b = r_b; w_last = 1'b1; end
          CMD_EQ:  begin alu_op = ALU_SUB; alu_a = r_a; alu_b = r_b; w_last = 1'b1; end
          CMD_NEG: begin
            if (r_step == '0) begin
              alu_op = ALU_NOT; alu_b = r_a;
            end else begin
              alu_op = ALU_ADD; alu_a = r_acc; alu_b = WORD'(1); w_last = 1'b1;
            end
          end
          CMD_XOR: begin
            case (r_step)
              STEP_W'(0): begin alu_op = ALU_AND; alu_a = r_a; alu_b = r_b; end
              STEP_W'(1): begin alu_op = ALU_NOT; alu_b = r_acc; end
              STEP_W'(2): begin alu_op = ALU_OR;  alu_a = r_a; alu_b = r_b; w_to_aux = 1'b1; end
              default:    begin alu_op = ALU_AND; alu_a = r_acc; alu_b = r_aux; w_last = 1'b1; end
            endcase
          end
          CMD_MUL: begin
            alu_a = r_acc;
            if (r_b[r_step]) begin
              alu_op = ALU_ADD;
              alu_b  = r_a << r_step;
            end
            w_last = (r_step == c_mul_last);
          end
          default: w_last = 1'b1;
        endcase
        if (w_last) w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cmd      <= CMD_ADD;
      r_a        <= '0;
      r_b        <= '0;
      r_acc      <= '0;
      r_aux      <= '0;
      r_step     <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_cmd  <= req_cmd;
            r_a    <= req_a;
            r_b    <= req_b;
            r_acc  <= '0;
            r_aux  <= '0;
            r_step <= '0;
          end
        end
        S_EXEC: begin
          if (w_to_aux) r_aux <= alu_result;
          else          r_acc <= alu_result;
          if (w_last) begin
            r_rsp_data <= w_rsp_next;
            r_rsp_zero <= (w_rsp_next == '0);
          end else begin
            r_step <= r_step + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
